test_harness_ctrl: RTL and testbench
====================================

TEST_HARNESS_CTRL -- requirements
Module: test_harness_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 3: number of cycles dut_rst is held high per test case.
REQ-002 Parameter TIMEOUT, default 10000: RUN cycle count at which a test case is aborted.
REQ-003 Parameter CW, default 32: width of the cycle counter.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  pulse that launches a test case; sampled in IDLE and DONE only.
REQ-007 case_id  in  8  test case number, latched on accepted start.
REQ-008 chk_valid  in  1  one check result presented this cycle.
REQ-009 chk_pass  in  1  result of that check; meaningful only when chk_valid=1.
REQ-010 end_req  in  1  bench declares the test case finished.
REQ-011 dut_rst  out  1  reset driven to the device under test.
REQ-012 running  out  1  high in RUN state.
REQ-013 done  out  1  high in DONE state.
REQ-014 passed  out  1  valid when done=1; 1 = no failed checks and no timeout.
REQ-015 timed_out  out  1  valid when done=1; 1 = case ended by watchdog.
REQ-016 cycles  out  CW  RUN cycles elapsed in current case.
REQ-017 n_checks / n_fails  out  16 each  checks seen / checks failed.
REQ-018 fail_cycle  out  CW  cycles value at first failed check; 0 if none.
REQ-019 cur_case  out  8  latched case_id.

Function
REQ-020 States IDLE, RST, RUN, DONE; encoding free.
REQ-021 IDLE: start=1 -> RST next cycle; latch case_id; clear cycles, n_checks, n_fails, fail_cycle, passed, timed_out.
REQ-022 RST: dut_rst=1 for exactly RST_CYCLES cycles via internal counter; cycles held 0; then RUN.
REQ-023 RUN: dut_rst=0, running=1; cycles increments by 1 each cycle, saturating at all-ones.
REQ-024 RUN, chk_valid=1: n_checks +1; if chk_pass=0, n_fails +1 and, if n_fails was 0, fail_cycle <= current cycles; both counters saturate at 16'hFFFF.
REQ-025 chk_valid outside RUN: ignored, no counter change.
REQ-026 RUN, end_req=1: -> DONE; passed = 1 iff n_fails, including any check in the same cycle, is 0; timed_out=0.
REQ-027 RUN, end_req=0 and cycles == TIMEOUT: -> DONE, timed_out=1, passed=0.
REQ-028 end_req and timeout condition in same cycle: end_req wins (REQ-026).
REQ-029 DONE: done=1; all result outputs frozen; dut_rst=0; start=1 -> RST with clearing per REQ-021.
REQ-030 start in RST or RUN: ignored.
REQ-031 end_req outside RUN: ignored.
REQ-032 Single-cycle latency: state and counter updates visible on the edge after the causing input.

Reset
REQ-033 rst=1 at any time, including mid-RUN: next state IDLE; dut_rst=0, running=0, done=0, passed=0, timed_out=0, all counters and cur_case 0.
REQ-034 rst dominates start, chk_valid and end_req in the same cycle.

Verification
REQ-035 start, case_id=5 in IDLE -> dut_rst high cycles 1-3, running from cycle 4, cur_case=5.
REQ-036 RUN, 4 checks all pass, end_req at cycles=20 -> done=1, passed=1, n_checks=4, n_fails=0, fail_cycle=0.
REQ-037 Failed checks at cycles=7 and 12, end_req -> n_fails=2, fail_cycle=7, passed=0.
REQ-038 TIMEOUT=50, no end_req -> DONE at cycles=50, timed_out=1, passed=0; end_req on same cycle as cycles=50 -> timed_out=0.
REQ-039 rst asserted at cycles=9 of RUN with n_checks=3 -> IDLE, all outputs 0; chk_valid during RST/IDLE leaves n_checks 0.
REQ-040 From DONE, start with case_id=6 -> counters cleared, RST reentered, cur_case=6.

Source files
------------

// File: rtl/test_harness_ctrl.sv
// Sequencer for one test case: pulses reset to the device under test, then runs it
// while tallying check results, until the bench ends the case or the watchdog fires.
module test_harness_ctrl #(
  parameter int unsigned RST_CYCLES = 3,
  parameter int unsigned TIMEOUT    = 10000,
  parameter int unsigned CW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    case_id,
  input  logic          chk_valid,
  input  logic          chk_pass,
  input  logic          end_req,
  output logic          dut_rst,
  output logic          running,
  output logic          done,
  output logic          passed,
  output logic          timed_out,
  output logic [CW-1:0] cycles,
  output logic [15:0]   n_checks,
  output logic [15:0]   n_fails,
  output logic [CW-1:0] fail_cycle,
  output logic [7:0]    cur_case
);

  localparam int unsigned   RCW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RstLast    = RCW'(RST_CYCLES - 1);
  localparam logic [CW-1:0]  TimeoutVal = CW'(TIMEOUT);
  localparam logic [CW-1:0]  CycMax     = '1;

  typedef enum logic [1:0] {StIdle, StRst, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [RCW-1:0]  rst_cnt_q, rst_cnt_d;
  logic [CW-1:0]   cycles_q, cycles_d;
  logic [CW-1:0]   fail_cycle_q, fail_cycle_d;
  logic [15:0]     n_checks_q, n_checks_d;
  logic [15:0]     n_fails_q, n_fails_d;
  logic            passed_q, passed_d;
  logic            timed_out_q, timed_out_d;
  logic [7:0]      cur_case_q, cur_case_d;

  logic launch;
  logic leave_run;

  assign launch    = ((state_q == StIdle) || (state_q == StDone)) && start;
  assign leave_run = (state_q == StRun) && (end_req || (cycles_q == TimeoutVal));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRst;
      StRst:   if (rst_cnt_q == RstLast) state_d = StRun;
      StRun:   if (end_req || (cycles_q == TimeoutVal)) state_d = StDone;
      StDone:  if (start) state_d = StRst;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    dut_rst    = (state_q == StRst);
    running    = (state_q == StRun);
    done       = (state_q == StDone);
    passed     = passed_q;
    timed_out  = timed_out_q;
    cycles     = cycles_q;
    n_checks   = n_checks_q;
    n_fails    = n_fails_q;
    fail_cycle = fail_cycle_q;
    cur_case   = cur_case_q;
  end

  // Counters and results
  always_comb begin
    rst_cnt_d    = rst_cnt_q;
    cycles_d     = cycles_q;
    fail_cycle_d = fail_cycle_q;
    n_checks_d   = n_checks_q;
    n_fails_d    = n_fails_q;
    passed_d     = passed_q;
    timed_out_d  = timed_out_q;
    cur_case_d   = cur_case_q;

    if (launch) begin
      rst_cnt_d    = '0;
      cycles_d     = '0;
      fail_cycle_d = '0;
      n_checks_d   = '0;
      n_fails_d    = '0;
      passed_d     = 1'b0;
      timed_out_d  = 1'b0;
      cur_case_d   = case_id;
    end else if (state_q == StRst) begin
      if (rst_cnt_q != RstLast) rst_cnt_d = rst_cnt_q + RCW'(1);
    end else if (state_q == StRun) begin
      if (chk_valid) begin
        if (n_checks_q != 16'hFFFF) n_checks_d = n_checks_q + 16'd1;
        if (!chk_pass) begin
          if (n_fails_q == 16'd0) fail_cycle_d = cycles_q;
          if (n_fails_q != 16'hFFFF) n_fails_d = n_fails_q + 16'd1;
        end
      end
      // A check arriving alongside end_req still counts toward the verdict.
      if (end_req) begin
        passed_d    = (n_fails_d == 16'd0);
        timed_out_d = 1'b0;
      end else if (cycles_q == TimeoutVal) begin
        passed_d    = 1'b0;
        timed_out_d = 1'b1;
      end
      if (!leave_run && (cycles_q != CycMax)) cycles_d = cycles_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_cnt_q    <= '0;
      cycles_q     <= '0;
      fail_cycle_q <= '0;
      n_checks_q   <= '0;
      n_fails_q    <= '0;
      passed_q     <= 1'b0;
      timed_out_q  <= 1'b0;
      cur_case_q   <= '0;
    end else begin
      rst_cnt_q    <= rst_cnt_d;
      cycles_q     <= cycles_d;
      fail_cycle_q <= fail_cycle_d;
      n_checks_q   <= n_checks_d;
      n_fails_q    <= n_fails_d;
      passed_q     <= passed_d;
      timed_out_q  <= timed_out_d;
      cur_case_q   <= cur_case_d;
    end
  end

endmodule

// File: tb/tb_test_harness_ctrl.sv
// Bench for test_harness_ctrl: directed scenarios plus random traffic, all checked
// against a case-lifecycle model that tracks launch age and finish status.
module tb_test_harness_ctrl;

  localparam int unsigned RstCycles = 3;
  localparam int unsigned Timeout   = 50;
  localparam int unsigned Cw        = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    case_id = 8'd0;
  logic          chk_valid = 1'b0;
  logic          chk_pass = 1'b0;
  logic          end_req = 1'b0;
  logic          dut_rst, running, done, passed, timed_out;
  logic [Cw-1:0] cycles, fail_cycle;
  logic [15:0]   n_checks, n_fails;
  logic [7:0]    cur_case;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Model: a case is "active" once launched, in reset for its first RstCycles edges,
  // then running until "finished".
  bit          m_active = 0, m_finished = 0, m_pass = 0, m_to = 0;
  int unsigned m_age = 0, m_cyc = 0, m_chk = 0, m_fail = 0, m_fc = 0;
  logic [7:0]  m_case = 8'd0;

  test_harness_ctrl #(
    .RST_CYCLES(RstCycles),
    .TIMEOUT   (Timeout),
    .CW        (Cw)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .case_id   (case_id),
    .chk_valid (chk_valid),
    .chk_pass  (chk_pass),
    .end_req   (end_req),
    .dut_rst   (dut_rst),
    .running   (running),
    .done      (done),
    .passed    (passed),
    .timed_out (timed_out),
    .cycles    (cycles),
    .n_checks  (n_checks),
    .n_fails   (n_fails),
    .fail_cycle(fail_cycle),
    .cur_case  (cur_case)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit s, input logic [7:0] id, input bit cv,
                            input bit cp, input bit er);
    if (r) begin
      m_active = 0; m_finished = 0; m_pass = 0; m_to = 0;
      m_age = 0; m_cyc = 0; m_chk = 0; m_fail = 0; m_fc = 0; m_case = 8'd0;
    end else if ((!m_active || m_finished) && s) begin
      m_active = 1; m_finished = 0; m_pass = 0; m_to = 0;
      m_age = 0; m_cyc = 0; m_chk = 0; m_fail = 0; m_fc = 0; m_case = id;
    end else if (m_active && !m_finished) begin
      if (m_age < RstCycles) begin
        m_age++;
      end else begin
        if (cv) begin
          if (m_chk < 65535) m_chk++;
          if (!cp) begin
            if (m_fail == 0) m_fc = m_cyc;
            if (m_fail < 65535) m_fail++;
          end
        end
        if (er) begin
          m_finished = 1; m_pass = (m_fail == 0); m_to = 0;
        end else if (m_cyc == Timeout) begin
          m_finished = 1; m_pass = 0; m_to = 1;
        end else if (m_cyc != 32'hFFFF_FFFF) begin
          m_cyc++;
        end
      end
    end
  endtask

  task automatic check_all();
    bit in_case;
    in_case = m_active && !m_finished;
    check("dut_rst",    32'(dut_rst),   32'(in_case && (m_age < RstCycles)));
    check("running",    32'(running),   32'(in_case && (m_age >= RstCycles)));
    check("done",       32'(done),      32'(m_finished));
    check("passed",     32'(passed),    32'(m_pass));
    check("timed_out",  32'(timed_out), 32'(m_to));
    check("cycles",     cycles,         m_cyc);
    check("n_checks",   32'(n_checks),  m_chk);
    check("n_fails",    32'(n_fails),   m_fail);
    check("fail_cycle", fail_cycle,     m_fc);
    check("cur_case",   32'(cur_case),  32'(m_case));
  endtask

  task automatic step(input bit r, input bit s, input logic [7:0] id, input bit cv,
                      input bit cp, input bit er);
    @(negedge clk);
    rst = r; start = s; case_id = id; chk_valid = cv; chk_pass = cp; end_req = er;
    @(posedge clk);
    model_edge(r, s, id, cv, cp, er);
    #1;
    check_all();
  endtask

  task automatic run_until(input int unsigned n);
    int guard = 0;
    while (m_active && !m_finished && (m_cyc < n) && (guard < 500)) begin
      step(0, 0, 8'd0, 0, 0, 0);
      guard++;
    end
  endtask

  initial begin
    step(1, 0, 8'd0, 0, 0, 0);
    step(1, 0, 8'd0, 0, 0, 0);

    // Launch case 5: reset pulse then run
    step(0, 1, 8'd5, 0, 0, 0);
    check("c1_dut_rst", 32'(dut_rst), 32'd1);
    step(0, 0, 8'd0, 0, 0, 0);
    step(0, 0, 8'd0, 0, 0, 0);
    check("c3_dut_rst", 32'(dut_rst), 32'd1);
    step(0, 0, 8'd0, 0, 0, 0);
    check("c4_running", 32'(running), 32'd1);
    check("c4_dut_rst", 32'(dut_rst), 32'd0);
    check("c4_cur_case", 32'(cur_case), 32'd5);

    // Four passing checks, end at cycles=20
    run_until(3);  step(0, 0, 8'd0, 1, 1, 0);
    run_until(5);  step(0, 0, 8'd0, 1, 1, 0);
    run_until(8);  step(0, 0, 8'd0, 1, 1, 0);
    run_until(11); step(0, 0, 8'd0, 1, 1, 0);
    run_until(20);
    step(0, 0, 8'd0, 0, 0, 1);
    check("pass_done", 32'(done), 32'd1);
    check("pass_passed", 32'(passed), 32'd1);
    check("pass_n_checks", 32'(n_checks), 32'd4);
    check("pass_n_fails", 32'(n_fails), 32'd0);
    check("pass_fail_cycle", fail_cycle, 32'd0);
    check("pass_cycles", cycles, 32'd20);
    step(0, 0, 8'd0, 1, 0, 1);
    check("done_frozen_checks", 32'(n_checks), 32'd4);

    // Restart from DONE with case 6; two failures
    step(0, 1, 8'd6, 0, 0, 0);
    check("restart_cur_case", 32'(cur_case), 32'd6);
    check("restart_n_checks", 32'(n_checks), 32'd0);
    check("restart_dut_rst", 32'(dut_rst), 32'd1);
    check("restart_done", 32'(done), 32'd0);
    run_until(7);  step(0, 0, 8'd0, 1, 0, 0);
    run_until(12); step(0, 0, 8'd0, 1, 0, 0);
    run_until(15); step(0, 0, 8'd0, 0, 0, 1);
    check("fail_n_fails", 32'(n_fails), 32'd2);
    check("fail_fail_cycle", fail_cycle, 32'd7);
    check("fail_passed", 32'(passed), 32'd0);

    // Watchdog, then end_req coinciding with the watchdog cycle
    step(0, 1, 8'd7, 0, 0, 0);
    run_until(Timeout);
    step(0, 0, 8'd0, 0, 0, 0);
    check("to_done", 32'(done), 32'd1);
    check("to_cycles", cycles, 32'd50);
    check("to_timed_out", 32'(timed_out), 32'd1);
    check("to_passed", 32'(passed), 32'd0);
    step(0, 1, 8'd8, 0, 0, 0);
    run_until(Timeout);
    step(0, 0, 8'd0, 0, 0, 1);
    check("tie_timed_out", 32'(timed_out), 32'd0);
    check("tie_done", 32'(done), 32'd1);

    // Reset mid-run dominates everything
    step(0, 1, 8'd9, 0, 0, 0);
    run_until(2);
    step(0, 0, 8'd0, 1, 1, 0);
    step(0, 0, 8'd0, 1, 0, 0);
    step(0, 0, 8'd0, 1, 1, 0);
    run_until(9);
    check("pre_rst_n_checks", 32'(n_checks), 32'd3);
    step(1, 1, 8'd3, 1, 0, 1);
    check("rst_running", 32'(running), 32'd0);
    check("rst_n_checks", 32'(n_checks), 32'd0);
    check("rst_cur_case", 32'(cur_case), 32'd0);
    check("rst_cycles", cycles, 32'd0);
    step(0, 0, 8'd0, 1, 0, 0);
    check("idle_chk_ignored", 32'(n_checks), 32'd0);
    step(0, 1, 8'd2, 1, 0, 0);
    step(0, 0, 8'd0, 1, 0, 0);
    check("rstphase_chk_ignored", 32'(n_checks), 32'd0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(199) == 0), ($urandom_range(19) == 0), 8'($urandom),
           ($urandom_range(2) == 0), ($urandom_range(3) != 0), ($urandom_range(59) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
